// File: rtl/merge_pipe_pkg.sv
// Shared constants, beat layout and arbitration helper for the merge_pipe block.
package merge_pipe_pkg;

  localparam int DEF_WIDTH = 128;
  localparam int DEF_NCH   = 4;
  localparam int DEF_DEPTH = 4;
  localparam int CHW       = $clog2(DEF_NCH);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [CHW-1:0]       chan;
  } beat_t;

  // First requester at or after 'start' (wrapping at n-1); start=0 gives fixed priority.
  function automatic logic [3:0] pick_chan(input logic [15:0] req, input logic [3:0] start, input int n);
    logic [3:0] res;
    logic [3:0] idx;
    res = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i < n) begin
        idx = 4'((int'(start) + i) % n);
        if (req[idx]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/merge_pipe_fifo.sv
// Per-channel circular FIFO with ENA/RDY enqueue and dequeue; head word exposed combinationally.
module merge_pipe_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enq_ena,
  input  logic [WIDTH-1:0] i_enq_v,
  output logic             o_enq_rdy,
  input  logic             i_deq_ena,
  output logic             o_deq_rdy,
  output logic [WIDTH-1:0] o_first
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_enq;
  logic             w_deq;

  assign o_enq_rdy = (r_count != CW'(DEPTH));
  assign o_deq_rdy = (r_count != '0);
  assign w_enq     = i_enq_ena & o_enq_rdy;
  assign w_deq     = i_deq_ena & o_deq_rdy;
  assign o_first   = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= i_enq_v;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_enq_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_enq_ena |-> o_enq_rdy);
  a_deq_when_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_deq_ena |-> o_deq_rdy);

endmodule

// File: rtl/merge_pipe.sv
// NCH-channel merge: per-channel FIFOs drained by an arbiter into one registered output port.
// Define MERGE_PIPE_RR_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module merge_pipe
  import merge_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NCH-1:0]           i_in_enq_ena,
  input  logic [NCH*WIDTH-1:0]     i_in_enq_v,
  output logic [NCH-1:0]           o_in_enq_rdy,
  output logic                     o_out_enq_ena,
  output logic [WIDTH-1:0]         o_out_enq_v,
  output logic [$clog2(NCH)-1:0]   o_out_enq_chan,
  input  logic                     i_out_enq_rdy,
  output logic                     o_busy
);

  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]       w_nonempty;
  logic [NCH-1:0]       w_deq;
  logic [NCH*WIDTH-1:0] w_first;
  logic                 w_load;
  logic                 w_any;
  logic [CH_W-1:0]      w_start;
  logic [CH_W-1:0]      w_grant;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [CH_W-1:0]      r_out_chan;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      merge_pipe_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_enq_ena (i_in_enq_ena[gi]),
        .i_enq_v   (i_in_enq_v[gi*WIDTH +: WIDTH]),
        .o_enq_rdy (o_in_enq_rdy[gi]),
        .i_deq_ena (w_deq[gi]),
        .o_deq_rdy (w_nonempty[gi]),
        .o_first   (w_first[gi*WIDTH +: WIDTH])
      );
      assign w_deq[gi] = w_load & w_any & (w_grant == CH_W'(gi));
    end
  endgenerate

  // The register may refill whenever it is empty or its beat leaves this cycle.
  assign w_load  = ~r_out_valid | i_out_enq_rdy;
  assign w_any   = |w_nonempty;
  assign w_grant = CH_W'(pick_chan(16'(w_nonempty), 4'(w_start), NCH));

`ifdef MERGE_PIPE_RR_EN
  logic [CH_W-1:0] r_rr_ptr;

  assign w_start = r_rr_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_load && w_any) begin
      r_rr_ptr <= (w_grant == CH_W'(NCH - 1)) ? '0 : w_grant + 1'b1;
    end
  end
`else
  assign w_start = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_first[w_grant*WIDTH +: WIDTH];
        r_out_chan  <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_enq_ena  = r_out_valid & i_out_enq_rdy;
  assign o_out_enq_v    = r_out_data;
  assign o_out_enq_chan = r_out_chan;
  assign o_busy         = w_any | r_out_valid;

endmodule

// File: tb/tb_merge_pipe.sv
// Directed and random checks of merge_pipe against per-channel queues and arbitration-order expectations.
module tb_merge_pipe;

  localparam int W = 128;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_ena;
  logic [N*W-1:0] in_v;
  logic [N-1:0]   in_rdy;
  logic           out_ena;
  logic [W-1:0]   out_v;
  logic [1:0]     out_chan;
  logic           out_rdy;
  logic           busy;

  merge_pipe dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_enq_ena   (in_ena),
    .i_in_enq_v     (in_v),
    .o_in_enq_rdy   (in_rdy),
    .o_out_enq_ena  (out_ena),
    .o_out_enq_v    (out_v),
    .o_out_enq_chan (out_chan),
    .i_out_enq_rdy  (out_rdy),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef logic [W-1:0] beat_q_t[$];
  beat_q_t    mq[N];
  int         chan_log[$];
  int         rx_cnt;
  bit         track_stall;
  bit         prev_stall;
  logic [W-1:0] stall_v;
  logic [1:0] stall_chan;
  int         exp_seq[8];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int c, input logic [W-1:0] d);
    in_ena[c] = 1'b1;
    in_v[c*W +: W] = d;
  endtask

  task automatic clear_in();
    in_ena = '0;
    in_v   = '0;
  endtask

  // Sampled at the falling edge: inputs and outputs are stable for the coming rising edge.
  task automatic monitor();
    for (int c = 0; c < N; c++)
      if (in_ena[c] && in_rdy[c]) mq[c].push_back(in_v[c*W +: W]);
    if (out_ena) begin
      int ch;
      ch = int'(out_chan);
      checks++;
      assert (mq[ch].size() != 0) else begin
        errors++;
        $error("FAIL spurious_beat chan=%0d observed=%0h expected=none", ch, out_v);
      end
      if (mq[ch].size() != 0) chk($sformatf("order_ch%0d", ch), out_v, mq[ch].pop_front());
      if (prev_stall) begin
        chk("stall_v", out_v, stall_v);
        chk("stall_chan", W'(out_chan), W'(stall_chan));
      end
      chan_log.push_back(ch);
      rx_cnt++;
    end
    prev_stall = track_stall && !out_rdy && (rx_cnt > 0);
    stall_v    = out_v;
    stall_chan = out_chan;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    int pend;
    n = 0;
    pend = 0;
    for (int c = 0; c < N; c++) pend += mq[c].size();
    while ((pend != 0 || busy) && n < max) begin
      tick();
      n++;
      pend = 0;
      for (int c = 0; c < N; c++) pend += mq[c].size();
    end
    checks++;
    assert (n < max) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d cycles expected=<%0d", tag, n, max);
    end
    chk({tag, "_idle"}, W'(busy), W'(1'b0));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_ena"}, W'(out_ena), W'(1'b0));
    chk({tag, "_in_rdy"}, W'(in_rdy), W'(4'hF));
    chk({tag, "_out_v"}, out_v, '0);
    chk({tag, "_out_chan"}, W'(out_chan), W'(2'd0));
    chk({tag, "_busy"}, W'(busy), W'(1'b0));
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, W'(chan_log.size()), W'(8));
    for (int i = 0; i < 8; i++)
      if (i < chan_log.size()) chk($sformatf("%s_chan%0d", tag, i), W'(chan_log[i]), W'(exp_seq[i]));
  endtask

  initial begin
    int sent;
    logic [W-1:0] pat;
    rst_n = 1'b1;
    clear_in();
    out_rdy = 1'b0;
    track_stall = 1'b0;
    prev_stall = 1'b0;
    rx_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    check_reset("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T2: empty-pipe latency, single beat on channel 2
    out_rdy = 1'b1;
    pat = {16{8'hAA}};
    set_beat(2, pat);
    tick();
    clear_in();
    chk("t2_not_bypassed", W'(out_ena), W'(1'b0));
    tick();
    chk("t2_out_ena", W'(out_ena), W'(1'b1));
    chk("t2_out_v", out_v, pat);
    chk("t2_out_chan", W'(out_chan), W'(2'd2));
    tick();
    chk("t2_single", W'(out_ena), W'(1'b0));

    // T3: fill channel 1 (4 in FIFO + 1 in output register) under backpressure
    out_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t3_rdy_before_%0d", k), W'(in_rdy[1]), W'(1'b1));
      set_beat(1, W'(k));
      tick();
      clear_in();
    end
    chk("t3_full", W'(in_rdy[1]), W'(1'b0));
    chk("t3_stalled", W'(out_ena), W'(1'b0));
    chk("t3_busy", W'(busy), W'(1'b1));
    tick();
    chk("t3_still_full", W'(in_rdy[1]), W'(1'b0));
    rx_cnt = 0;
    out_rdy = 1'b1;
    drain("t3", 50);
    chk("t3_count", W'(rx_cnt), W'(5));

    // T4: channel 0 streams 0..15 while output ready toggles
    rx_cnt = 0;
    sent = 0;
    track_stall = 1'b1;
    for (int cyc = 0; cyc < 200 && rx_cnt < 16; cyc++) begin
      clear_in();
      out_rdy = cyc[0];
      if (sent < 16 && in_rdy[0]) begin
        set_beat(0, W'(sent));
        sent++;
      end
      tick();
    end
    track_stall = 1'b0;
    prev_stall = 1'b0;
    clear_in();
    out_rdy = 1'b1;
    chk("t4_count", W'(rx_cnt), W'(16));
    drain("t4", 50);

    // T5: channels 0 and 3 each preload 4 beats
    out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_beat(0, W'(32'h100 + k));
      set_beat(3, W'(32'h300 + k));
      tick();
      clear_in();
    end
    chk("t5_ch3_full", W'(in_rdy[3]), W'(1'b0));
    chk("t5_ch0_room", W'(in_rdy[0]), W'(1'b1));
    chan_log.delete();
`ifdef MERGE_PIPE_RR_EN
    exp_seq = '{0, 3, 0, 3, 0, 3, 0, 3};
`else
    exp_seq = '{0, 0, 0, 0, 3, 3, 3, 3};
`endif
    out_rdy = 1'b1;
    drain("t5", 50);
    check_seq("t5");

`ifdef MERGE_PIPE_RR_EN
    // T6: all channels preload 2 beats; pointer wraps 3 -> 0
    out_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) set_beat(c, W'(c * 16 + k));
      tick();
      clear_in();
    end
    chan_log.delete();
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    out_rdy = 1'b1;
    drain("t6", 50);
    check_seq("t6");
`endif

    // T1: reset with beats queued drops everything at once
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_beat(1, W'(32'hB0 + k));
      tick();
      clear_in();
    end
    chk("t1_busy_before", W'(busy), W'(1'b1));
    rst_n = 1'b0;
    #1;
    check_reset("t1");
    for (int c = 0; c < N; c++) mq[c].delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_after_release_busy", W'(busy), W'(1'b0));

    // Random traffic
    rx_cnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_in();
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) begin
        if (in_rdy[c] && $urandom_range(0, 2) == 0) begin
          set_beat(c, {$urandom, $urandom, $urandom, $urandom});
          sent++;
        end
      end
      tick();
    end
    clear_in();
    out_rdy = 1'b1;
    drain("rand", 400);
    chk("rand_count", W'(rx_cnt), W'(sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
